fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined ARM core: PC register, ROM address generation and IF/ID pipeline register, replacing the inline PC logic at top level.
- Drives the ROM address and captures the returned instruction.
- Applies the ID-stage stall and the MEM-stage branch redirect.
- Detects a halt opcode so simulation can end cleanly; keeps fetch/stall/flush counters for CPI measurement.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM addressing, IF/ID register, halt detection
// and saturating fetch/stall/flush counters for CPI measurement.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PC_INC     = 32'd1,
    parameter logic [31:0] NOP_INSTR  = 32'hD503_201F,
    parameter logic [31:0] HALT_INSTR = 32'hD440_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_ID,
    input  logic        branch_taken_MEM,
    input  logic [31:0] branch_PC_MEM,
    input  logic [31:0] rom_instr,
    output logic [31:0] rom_addr,
    output logic [31:0] instr_ID,
    output logic [31:0] PC_ID,
    output logic        valid_ID,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic {StRun, StHalted} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_id_q;
    logic        valid_q;
    logic [31:0] fetch_q;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Priority: reset > branch > stall > halt detect > normal fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc_id_q <= 32'd0;
            valid_q <= 1'b0;
            fetch_q <= 32'd0;
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else if (branch_taken_MEM) begin
            state_q <= StRun;
            pc_q    <= branch_PC_MEM;
            instr_q <= NOP_INSTR;
            pc_id_q <= 32'd0;
            valid_q <= 1'b0;
            flush_q <= sat_inc(flush_q);
        end else if (stall_ID) begin
            stall_q <= sat_inc(stall_q);
        end else if (state_q == StRun) begin
            instr_q <= rom_instr;
            pc_id_q <= pc_q;
            valid_q <= 1'b1;
            fetch_q <= sat_inc(fetch_q);
            if (rom_instr == HALT_INSTR) begin
                state_q <= StHalted;
            end else begin
                pc_q <= pc_q + PC_INC;
            end
        end else begin
            // Halted: keep issuing bubbles until a branch restarts fetch.
            instr_q <= NOP_INSTR;
            pc_id_q <= 32'd0;
            valid_q <= 1'b0;
        end
    end

    assign rom_addr    = pc_q;
    assign instr_ID    = instr_q;
    assign PC_ID       = pc_id_q;
    assign valid_ID    = valid_q;
    assign halted      = (state_q == StHalted);
    assign fetch_count = fetch_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a behavioural ROM:
// ROM[a] = 0x1000 + a, except ROM[6] which holds the halt opcode.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'hD503_201F;
    localparam logic [31:0] HALT = 32'hD440_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_ID;
    logic        branch_taken_MEM;
    logic [31:0] branch_PC_MEM;
    logic [31:0] rom_instr;
    logic [31:0] rom_addr;
    logic [31:0] instr_ID;
    logic [31:0] PC_ID;
    logic        valid_ID;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int checks = 0;
    int failures = 0;

    fetch_stage dut (
        .clock            (clock),
        .reset            (reset),
        .stall_ID         (stall_ID),
        .branch_taken_MEM (branch_taken_MEM),
        .branch_PC_MEM    (branch_PC_MEM),
        .rom_instr        (rom_instr),
        .rom_addr         (rom_addr),
        .instr_ID         (instr_ID),
        .PC_ID            (PC_ID),
        .valid_ID         (valid_ID),
        .halted           (halted),
        .fetch_count      (fetch_count),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a == 32'd6) ? HALT : 32'h1000 + a;
    endfunction

    always_comb rom_instr = rom_fn(rom_addr);

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcid;
        logic        valid;
        logic        halt;
        logic [31:0] fc;
        logic [31:0] sc;
        logic [31:0] xc;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl[NVEC];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bp,
                                input logic [31:0] ad, input logic [31:0] in,
                                input logic [31:0] pi, input logic v, input logic h,
                                input logic [31:0] f, input logic [31:0] st,
                                input logic [31:0] fl);
        vec_t r;
        r.stall = s; r.br = b; r.bpc = bp; r.addr = ad; r.instr = in; r.pcid = pi;
        r.valid = v; r.halt = h; r.fc = f; r.sc = st; r.xc = fl;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t e);
        chk("rom_addr", idx, rom_addr, e.addr);
        chk("instr_ID", idx, instr_ID, e.instr);
        chk("PC_ID", idx, PC_ID, e.pcid);
        chk("valid_ID", idx, {31'd0, valid_ID}, {31'd0, e.valid});
        chk("halted", idx, {31'd0, halted}, {31'd0, e.halt});
        chk("fetch_count", idx, fetch_count, e.fc);
        chk("stall_count", idx, stall_count, e.sc);
        chk("flush_count", idx, flush_count, e.xc);
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bp);
        reset = r;
        stall_ID = s;
        branch_taken_MEM = b;
        branch_PC_MEM = bp;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t rst_v;
        rst_v = mk(0, 0, 0, 32'd0, NOP, 32'd0, 0, 0, 0, 0, 0);

        //             stall br bpc            addr          instr          pcid          v  h  fc  sc  xc
        tbl[0]  = mk(0, 0, 0,            32'd1,        32'h1000,      32'd0,        1, 0, 1,  0, 0);
        tbl[1]  = mk(0, 0, 0,            32'd2,        32'h1001,      32'd1,        1, 0, 2,  0, 0);
        tbl[2]  = mk(0, 0, 0,            32'd3,        32'h1002,      32'd2,        1, 0, 3,  0, 0);
        tbl[3]  = mk(1, 0, 0,            32'd3,        32'h1002,      32'd2,        1, 0, 3,  1, 0);
        tbl[4]  = mk(1, 0, 0,            32'd3,        32'h1002,      32'd2,        1, 0, 3,  2, 0);
        tbl[5]  = mk(0, 0, 0,            32'd4,        32'h1003,      32'd3,        1, 0, 4,  2, 0);
        tbl[6]  = mk(0, 0, 0,            32'd5,        32'h1004,      32'd4,        1, 0, 5,  2, 0);
        tbl[7]  = mk(0, 0, 0,            32'd6,        32'h1005,      32'd5,        1, 0, 6,  2, 0);
        tbl[8]  = mk(0, 0, 0,            32'd6,        HALT,          32'd6,        1, 1, 7,  2, 0);
        tbl[9]  = mk(0, 0, 0,            32'd6,        NOP,           32'd0,        0, 1, 7,  2, 0);
        tbl[10] = mk(0, 0, 0,            32'd6,        NOP,           32'd0,        0, 1, 7,  2, 0);
        tbl[11] = mk(1, 0, 0,            32'd6,        NOP,           32'd0,        0, 1, 7,  3, 0);
        tbl[12] = mk(0, 1, 32'h10,       32'h10,       NOP,           32'd0,        0, 0, 7,  3, 1);
        tbl[13] = mk(0, 0, 0,            32'h11,       32'h1010,      32'h10,       1, 0, 8,  3, 1);
        tbl[14] = mk(1, 1, 32'h40,       32'h40,       NOP,           32'd0,        0, 0, 8,  3, 2);
        tbl[15] = mk(0, 0, 0,            32'h41,       32'h1040,      32'h40,       1, 0, 9,  3, 2);
        tbl[16] = mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NOP,         32'd0,        0, 0, 9,  3, 3);
        tbl[17] = mk(0, 0, 0,            32'd0,        32'h0000_0FFF, 32'hFFFF_FFFF, 1, 0, 10, 3, 3);
        tbl[18] = mk(0, 0, 0,            32'd1,        32'h1000,      32'd0,        1, 0, 11, 3, 3);
        tbl[19] = mk(0, 1, 32'd6,        32'd6,        NOP,           32'd0,        0, 0, 11, 3, 4);
        // ROM shows the halt opcode here, but the branch squashes it.
        tbl[20] = mk(0, 1, 32'h20,       32'h20,       NOP,           32'd0,        0, 0, 11, 3, 5);
        tbl[21] = mk(0, 0, 0,            32'h21,       32'h1020,      32'h20,       1, 0, 12, 3, 5);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_all(-1, rst_v);

        for (int i = 0; i < NVEC; i++) begin
            step(0, tbl[i].stall, tbl[i].br, tbl[i].bpc);
            chk_all(i, tbl[i]);
        end

        // Reset during a stall with a pending branch wins over both.
        step(0, 1, 0, 0);
        step(1, 1, 1, 32'h80);
        chk_all(100, rst_v);

        // Reset held over a halt-free restart, then the first edge out fetches ROM[0].
        step(0, 0, 0, 0);
        chk_all(101, mk(0, 0, 0, 32'd1, 32'h1000, 32'd0, 1, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
